// File: rtl/mul_pipe_unit.sv
// rtl/mul_pipe_unit.sv - three-stage pipelined multiplier with speculative-tag squash
module mul_pipe_unit #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  input  logic [DATA_LEN-1:0]    ex_src1,
  input  logic [DATA_LEN-1:0]    ex_src2,
  input  logic                   src1_signed,
  input  logic                   src2_signed,
  input  logic                   sel_lohi,
  input  logic [RRF_SEL-1:0]     rrftag,
  input  logic                   dstval,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic                   specbit,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic [DATA_LEN-1:0]    exrslt,
  output logic [RRF_SEL-1:0]     exdst,
  output logic                   rslt_valid,
  output logic                   kill_spec,
  output logic [SPECTAG_LEN-1:0] out_spectag,
  output logic                   out_specbit
);

  // Stage 1: operands and control
  logic                   s1_valid, s1_dstval, s1_specbit;
  logic [RRF_SEL-1:0]     s1_rrftag;
  logic [SPECTAG_LEN-1:0] s1_spectag;
  logic [DATA_LEN-1:0]    s1_src1, s1_src2;
  logic                   s1_src1_signed, s1_src2_signed, s1_sel_lohi;

  // Stage 2: full product and control
  logic                   s2_valid, s2_dstval, s2_specbit;
  logic [RRF_SEL-1:0]     s2_rrftag;
  logic [SPECTAG_LEN-1:0] s2_spectag;
  logic [2*DATA_LEN-1:0]  s2_prod;
  logic                   s2_sel_lohi;

  // Stage 3: selected word and control
  logic                   s3_valid, s3_dstval, s3_specbit;
  logic [RRF_SEL-1:0]     s3_rrftag;
  logic [SPECTAG_LEN-1:0] s3_spectag;
  logic [DATA_LEN-1:0]    s3_rslt;

  // Valid/specbit of each entry as it lands in the next stage after branch resolution
  logic in_valid, in_specbit, n1_valid, n1_specbit, n2_valid, n2_specbit;

  // Extended operands; the signed product of the 33-bit values taken mod 2^64
  logic signed [DATA_LEN:0]     ext1, ext2;
  logic signed [2*DATA_LEN-1:0] prod;
  logic [DATA_LEN-1:0]          sel_word;

  assign ext1     = {s1_src1_signed & s1_src1[DATA_LEN-1], s1_src1};
  assign ext2     = {s1_src2_signed & s1_src2[DATA_LEN-1], s1_src2};
  assign prod     = ext1 * ext2;
  assign sel_word = s2_sel_lohi ? s2_prod[2*DATA_LEN-1:DATA_LEN] : s2_prod[DATA_LEN-1:0];

  // Squash entries whose tag hits a mispredicted branch; prmiss wipes every surviving
  // specbit and dominates prsuccess, which only clears entries matching prtag.
  always_comb begin
    in_valid   = issue;
    in_specbit = specbit;
    n1_valid   = s1_valid;
    n1_specbit = s1_specbit;
    n2_valid   = s2_valid;
    n2_specbit = s2_specbit;
    if (prmiss) begin
      in_valid   = issue    & ((spectag    & specfixtag) == '0);
      n1_valid   = s1_valid & ((s1_spectag & specfixtag) == '0);
      n2_valid   = s2_valid & ((s2_spectag & specfixtag) == '0);
      in_specbit = 1'b0;
      n1_specbit = 1'b0;
      n2_specbit = 1'b0;
    end else if (prsuccess) begin
      if (spectag    == prtag) in_specbit = 1'b0;
      if (s1_spectag == prtag) n1_specbit = 1'b0;
      if (s2_spectag == prtag) n2_specbit = 1'b0;
    end
  end

  // Pipeline advance; result word and tag load only for entries that will broadcast
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_dstval      <= 1'b0;
      s1_specbit     <= 1'b0;
      s1_rrftag      <= '0;
      s1_spectag     <= '0;
      s1_src1        <= '0;
      s1_src2        <= '0;
      s1_src1_signed <= 1'b0;
      s1_src2_signed <= 1'b0;
      s1_sel_lohi    <= 1'b0;
      s2_valid       <= 1'b0;
      s2_dstval      <= 1'b0;
      s2_specbit     <= 1'b0;
      s2_rrftag      <= '0;
      s2_spectag     <= '0;
      s2_prod        <= '0;
      s2_sel_lohi    <= 1'b0;
      s3_valid       <= 1'b0;
      s3_dstval      <= 1'b0;
      s3_specbit     <= 1'b0;
      s3_rrftag      <= '0;
      s3_spectag     <= '0;
      s3_rslt        <= '0;
    end else begin
      s1_valid       <= in_valid;
      s1_dstval      <= dstval;
      s1_specbit     <= in_specbit;
      s1_rrftag      <= rrftag;
      s1_spectag     <= spectag;
      s1_src1        <= ex_src1;
      s1_src2        <= ex_src2;
      s1_src1_signed <= src1_signed;
      s1_src2_signed <= src2_signed;
      s1_sel_lohi    <= sel_lohi;
      s2_valid       <= n1_valid;
      s2_dstval      <= s1_dstval;
      s2_specbit     <= n1_specbit;
      s2_rrftag      <= s1_rrftag;
      s2_spectag     <= s1_spectag;
      s2_prod        <= prod;
      s2_sel_lohi    <= s1_sel_lohi;
      s3_valid       <= n2_valid;
      s3_dstval      <= s2_dstval;
      s3_specbit     <= n2_specbit;
      s3_spectag     <= s2_spectag;
      if (n2_valid && s2_dstval) begin
        s3_rslt   <= sel_word;
        s3_rrftag <= s2_rrftag;
      end
    end
  end

  assign exrslt      = s3_rslt;
  assign exdst       = s3_rrftag;
  assign rslt_valid  = s3_valid & s3_dstval;
  assign kill_spec   = prmiss & s3_valid & ((s3_spectag & specfixtag) != '0);
  assign out_spectag = s3_spectag;
  assign out_specbit = s3_specbit;

endmodule
